// File: rtl/sig_capture_pkg.sv
// Shared types and sizing for the signal capture monitor.
// Record field widths come from the package constants below; the top's
// default parameters match them.
package sig_capture_pkg;

  // Channel index width, never narrower than one bit.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CAP_MON_SIZE   = 5;
  localparam int CAP_MON_WIDTH  = 32;
  localparam int CAP_TS_WIDTH   = 32;
  localparam int CAP_FIFO_DEPTH = 16;

  localparam int IDX_W = calc_idx_w(CAP_MON_SIZE);
  localparam int LVL_W = $clog2(CAP_FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [IDX_W-1:0]         index;
    logic [CAP_MON_WIDTH-1:0] value;
    logic [CAP_TS_WIDTH-1:0]  timestamp;
  } cap_rec_t;

endpackage

// File: rtl/sig_capture_monitor_fifo.sv
// Synchronous show-ahead FIFO of capture records with full/empty/level.
// A push while full is accepted only when a pop happens in the same cycle.
module capture_fifo
  import sig_capture_pkg::*;
#(
  parameter int DEPTH = CAP_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  cap_rec_t               din,
  input  logic                   pop,
  output cap_rec_t               dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  cap_rec_t       mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; extra MSB separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates the outputs.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sig_capture_monitor.sv
// Signal capture monitor: samples MON_SIZE buses through a two-stage sampler,
// detects changes, holds one pending change per channel and drains them by
// lowest-index priority into a show-ahead record FIFO.
// Optional: CAPTURE_DROP_CNT_EN adds a saturating drop_count output.
module sig_capture_monitor
  import sig_capture_pkg::*;
#(
  parameter int MON_SIZE   = CAP_MON_SIZE,
  parameter int MON_WIDTH  = CAP_MON_WIDTH,
  parameter int TS_WIDTH   = CAP_TS_WIDTH,
  parameter int FIFO_DEPTH = CAP_FIFO_DEPTH,
  localparam int IW = calc_idx_w(MON_SIZE),
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [MON_SIZE-1:0]           mon_mask,
  input  logic [MON_SIZE*MON_WIDTH-1:0] mon_signals,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [IW-1:0]                 rd_index,
  output logic [MON_WIDTH-1:0]          rd_value,
  output logic [TS_WIDTH-1:0]           rd_timestamp,
  output logic [LW-1:0]                 fifo_level,
  output logic                          overflow,
`ifdef CAPTURE_DROP_CNT_EN
  output logic [15:0]                   drop_count,
`endif
  input  logic                          clr_overflow
);

  logic [TS_WIDTH-1:0]                ts_cnt;
  logic [MON_SIZE-1:0][MON_WIDTH-1:0] s1, s2, pend_val;
  logic [MON_SIZE-1:0][TS_WIDTH-1:0]  pend_ts;
  logic [MON_SIZE-1:0]                pending, det, ovw, push_oh;
  logic                               armed, have_win, push, pop, full, empty;
  logic [IW-1:0]                      win_idx;
  cap_rec_t                           rec_in, rec_out;

  // Free-running timestamp and two-stage input sampler; armed tracks enable
  // one edge late so the first enabled edge never reports the baseline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      s1     <= '0;
      s2     <= '0;
      armed  <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      s1     <= mon_signals;
      s2     <= s1;
      armed  <= enable;
    end
  end

  // Per-channel change detection on the sampled pair.
  always_comb begin
    det = '0;
    for (int i = 0; i < MON_SIZE; i++)
      det[i] = enable & armed & mon_mask[i] & (s1[i] != s2[i]);
  end

  // Fixed-priority pick of the lowest pending channel.
  always_comb begin
    have_win = 1'b0;
    win_idx  = '0;
    for (int i = MON_SIZE - 1; i >= 0; i--) begin
      if (pending[i]) begin
        have_win = 1'b1;
        win_idx  = IW'(i);
      end
    end
  end

  assign rd_valid = ~empty;
  assign pop      = rd_valid & rd_ready;
  // Full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = have_win & (~full | pop);
  assign push_oh  = push ? (MON_SIZE'(1) << win_idx) : '0;
  // A new change on a channel whose previous change was not pushed this cycle.
  assign ovw      = det & pending & ~push_oh;

  assign rec_in.index     = IDX_W'(win_idx);
  assign rec_in.value     = CAP_MON_WIDTH'(pend_val[win_idx]);
  assign rec_in.timestamp = CAP_TS_WIDTH'(pend_ts[win_idx]);

  // Pending slots: push clears, a same-cycle detection re-arms with new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      pend_val <= '0;
      pend_ts  <= '0;
    end else begin
      pending <= (pending & ~push_oh) | det;
      for (int i = 0; i < MON_SIZE; i++) begin
        if (det[i]) begin
          pend_val[i] <= s1[i];
          pend_ts[i]  <= ts_cnt;
        end
      end
    end
  end

  // Sticky overflow; a new overwrite beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow <= 1'b0;
    else if (|ovw)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

`ifdef CAPTURE_DROP_CNT_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_count} + 17'($countones(ovw));

  // Saturating count of overwrites; a clear is ignored when new drops land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               drop_count <= '0;
    else if (|ovw)         drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    else if (clr_overflow) drop_count <= '0;
  end
`endif

  capture_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rec_in),
    .pop   (pop),
    .dout  (rec_out),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Record fields read as zero whenever nothing is queued.
  assign rd_index     = rd_valid ? IW'(rec_out.index)            : '0;
  assign rd_value     = rd_valid ? MON_WIDTH'(rec_out.value)     : '0;
  assign rd_timestamp = rd_valid ? TS_WIDTH'(rec_out.timestamp)  : '0;

endmodule

// File: tb/tb_sig_capture_monitor.sv
// Self-checking bench for sig_capture_monitor: directed scenarios plus random
// traffic, compared every cycle against a queue-based behavioural model.
module tb_sig_capture_monitor;

  localparam int N = 5;
  localparam int W = 32;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [N-1:0]     mon_mask;
  logic [N*W-1:0]   mon_signals;
  logic             rd_ready;
  logic             rd_valid;
  logic [2:0]       rd_index;
  logic [W-1:0]     rd_value;
  logic [31:0]      rd_timestamp;
  logic [4:0]       fifo_level;
  logic             overflow;
  logic             clr_overflow;
`ifdef CAPTURE_DROP_CNT_EN
  logic [15:0]      drop_count;
`endif

  logic [W-1:0] sig [N];

  always #5 clk = ~clk;

  always_comb begin
    mon_signals = '0;
    for (int i = 0; i < N; i++) mon_signals[i*W +: W] = sig[i];
  end

  sig_capture_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mon_mask     (mon_mask),
    .mon_signals  (mon_signals),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_index     (rd_index),
    .rd_value     (rd_value),
    .rd_timestamp (rd_timestamp),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
`ifdef CAPTURE_DROP_CNT_EN
    .drop_count   (drop_count),
`endif
    .clr_overflow (clr_overflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int idx; logic [31:0] val; logic [31:0] ts; } mrec_t;
  mrec_t       mq[$];
  logic [31:0] m_s1 [N], m_s2 [N], m_pv [N], m_pt [N];
  bit          m_pend [N];
  bit          m_armed, m_ovf;
  logic [31:0] m_ts;
  int          m_drop;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < N; i++) begin
      m_s1[i] = '0; m_s2[i] = '0; m_pv[i] = '0; m_pt[i] = '0; m_pend[i] = 0;
    end
    m_armed = 0; m_ovf = 0; m_ts = '0; m_drop = 0;
  endtask

  // One clock edge: oldest record leaves if the reader takes it, then the
  // lowest waiting channel enters if there is room, then new changes land.
  task automatic model_step();
    bit    det [N];
    int    ev;
    mrec_t r;
    ev = 0;
    for (int i = 0; i < N; i++)
      det[i] = enable && mon_mask[i] && m_armed && (m_s1[i] != m_s2[i]);
    if (rd_ready && mq.size() > 0) void'(mq.pop_front());
    if (mq.size() < DEPTH) begin
      for (int i = 0; i < N; i++) begin
        if (m_pend[i]) begin
          r.idx = i; r.val = m_pv[i]; r.ts = m_pt[i];
          mq.push_back(r);
          m_pend[i] = 0;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (det[i]) begin
        if (m_pend[i]) ev++;
        m_pend[i] = 1; m_pv[i] = m_s1[i]; m_pt[i] = m_ts;
      end
    end
    if (ev > 0) begin
      m_ovf = 1;
      m_drop = (m_drop + ev > 65535) ? 65535 : m_drop + ev;
    end else if (clr_overflow) begin
      m_ovf = 0;
      m_drop = 0;
    end
    for (int i = 0; i < N; i++) begin
      m_s2[i] = m_s1[i];
      m_s1[i] = sig[i];
    end
    m_armed = enable;
    m_ts = m_ts + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("valid", rd_valid, mq.size() > 0);
        chk("level", fifo_level, mq.size());
        chk("ovf", overflow, m_ovf);
`ifdef CAPTURE_DROP_CNT_EN
        chk("drop", drop_count, m_drop);
`endif
        if (mq.size() > 0) begin
          chk("idx", rd_index, mq[0].idx);
          chk("val", rd_value, mq[0].val);
          chk("ts", rd_timestamp, mq[0].ts);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  int          nv, c_idx [8], c_tk [8];
  logic [31:0] c_ts [8], c_val [8];

  // Watch n cycles and record every cycle with rd_valid high.
  task automatic collect(input int ncyc);
    nv = 0;
    for (int t = 0; t < ncyc; t++) begin
      tick();
      if (rd_valid && nv < 8) begin
        c_idx[nv] = rd_index; c_val[nv] = rd_value; c_ts[nv] = rd_timestamp; c_tk[nv] = t;
      end
      if (rd_valid) nv++;
    end
  endtask

  initial begin
    rst = 1; enable = 0; mon_mask = '1; rd_ready = 0; clr_overflow = 0;
    for (int i = 0; i < N; i++) sig[i] = '0;
    repeat (3) tick();
    chk("rst_valid", rd_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_idx", rd_index, 0);
    chk("rst_val", rd_value, 0);
    chk("rst_ts", rd_timestamp, 0);
    rst = 0; enable = 1; rd_ready = 1;

    // Single change on ch2 while the counter reads 10.
    while (m_ts != 10) tick();
    sig[2] = 32'hCAFEDECA;
    collect(6);
    chk("single_cnt", nv, 1);
    chk("single_idx", c_idx[0], 2);
    chk("single_val", c_val[0], 32'hCAFEDECA);
    chk("single_ts", c_ts[0], 11);

    // Simultaneous changes on ch0, ch3, ch4.
    sig[0] = 32'h1; sig[3] = 32'h3; sig[4] = 32'h4;
    collect(8);
    chk("simul_cnt", nv, 3);
    chk("simul_i0", c_idx[0], 0);
    chk("simul_i1", c_idx[1], 3);
    chk("simul_i2", c_idx[2], 4);
    chk("simul_ts1", c_ts[1], c_ts[0]);
    chk("simul_ts2", c_ts[2], c_ts[0]);
    chk("simul_b2b1", c_tk[1], c_tk[0] + 1);
    chk("simul_b2b2", c_tk[2], c_tk[0] + 2);

    // Masked channel and baseline at arming give nothing.
    mon_mask = 5'b11110;
    nv = 0;
    for (int t = 0; t < 4; t++) begin
      sig[0] = ~sig[0];
      tick();
      if (rd_valid) nv++;
    end
    enable = 0; tick(); tick();
    sig[1] = 32'h55555555;
    tick();
    enable = 1;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (rd_valid) nv++;
    end
    chk("maskarm_none", nv, 0);
    sig[1] = 32'h0;
    collect(6);
    chk("arm_cnt", nv, 1);
    chk("arm_idx", c_idx[0], 1);
    chk("arm_val", c_val[0], 0);
    mon_mask = '1;

    // Fill: 18 alternating changes with the reader stalled.
    rd_ready = 0;
    for (int k = 0; k < 18; k++) begin
      sig[1 + (k % 2)] = 32'd100 + k;
      tick();
    end
    repeat (4) tick();
    chk("full_level", fifo_level, 16);
    chk("full_noovf", overflow, 0);
    sig[1] = 32'hABCD;
    repeat (3) tick();
    chk("full_ovf", overflow, 1);
`ifdef CAPTURE_DROP_CNT_EN
    chk("full_drop", drop_count, 1);
`endif

    // Drain: push and pop together while full, then empty out.
    rd_ready = 1;
    begin
      int nrec;
      nrec = 0;
      for (int c = 0; c < 40; c++) begin
        if (c == 1) chk("pp_level1", fifo_level, 16);
        if (c == 2) chk("pp_level2", fifo_level, 16);
        if (c == 3) chk("pp_level3", fifo_level, 15);
        if (rd_valid) begin
          if (nrec < 16) begin
            chk("drain_idx", rd_index, 1 + (nrec % 2));
            chk("drain_val", rd_value, 100 + nrec);
          end else if (nrec == 16) begin
            chk("drain_idx16", rd_index, 1);
            chk("drain_val16", rd_value, 32'hABCD);
          end else begin
            chk("drain_idx17", rd_index, 2);
            chk("drain_val17", rd_value, 117);
          end
          nrec++;
        end
        tick();
      end
      chk("drain_cnt", nrec, 18);
    end
    clr_overflow = 1; tick(); clr_overflow = 0; tick();
    chk("clr_ovf", overflow, 0);

    // Random traffic with alternating reader-stall phases.
    for (int c = 0; c < 1500; c++) begin
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) mon_mask = N'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0)
          sig[i] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      rd_ready = ((c / 100) % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      clr_overflow = ($urandom_range(0, 39) == 0);
      tick();
    end
    clr_overflow = 0; enable = 1; mon_mask = '1; rd_ready = 1;
    for (int c = 0; c < 60 && rd_valid; c++) tick();
    repeat (6) tick();
    chk("rand_drained", rd_valid, 0);

    // Reset mid-queue with overflow set.
    rd_ready = 0;
    for (int i = 0; i < N; i++) sig[i] = sig[i] + 32'h1000;
    tick();
    sig[4] = sig[4] + 32'h1;
    repeat (8) tick();
    chk("pre_rst_level", fifo_level, 5);
    chk("pre_rst_ovf", overflow, 1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ovf", overflow, 0);
    enable = 0;
    @(negedge clk);
    rst = 0;
    repeat (3) tick();
    enable = 1; rd_ready = 1;
    while (m_ts != 6) tick();
    sig[3] = sig[3] ^ 32'h00FF00FF;
    collect(6);
    chk("post_rst_cnt", nv, 1);
    chk("post_rst_idx", c_idx[0], 3);
    chk("post_rst_ts", c_ts[0], 7);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
